// File: rtl/bcd_clock_alarm.sv
// BCD hh:mm:ss wall clock with 12h/24h mode, seconds prescaler, checked time load and hh:mm alarm.
// Outputs are registered: load or a qualifying ena shows up one cycle later; no backpressure, ena just pauses.
module bcd_clock_alarm #(
    parameter int TICK_DIV = 1,
    parameter bit ALARM_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       mode24,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       ld_pm,
    input  logic       alm_wr,
    input  logic [7:0] alm_hh,
    input  logic [7:0] alm_mm,
    input  logic       alm_pm,
    input  logic       alarm_on,
    input  logic       alarm_ack,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       sec_tick,
    output logic       load_err,
    output logic       alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd9) begin
            hi = hi + 4'd1;
            lo = 4'd0;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    logic          mode_q, mode_d;
    logic [7:0]    hh_q, hh_d;
    logic [7:0]    mm_q, mm_d;
    logic [7:0]    ss_q, ss_d;
    logic          pm_q, pm_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          sec_tick_q, sec_tick_d;
    logic          load_err_q, load_err_d;

    logic [7:0]    hh_adv, mm_adv, ss_adv;
    logic          pm_adv;
    logic          adv;
    logic          ld_hh_ok;
    logic          ld_ok;

    // A load in the same cycle always pre-empts the second advance.
    assign adv = ena && !load && (pcnt_q == PLAST);

    always_comb begin
        ld_hh_ok = bcd_ok(ld_hh) &&
                   (mode24 ? (ld_hh <= 8'h23) : ((ld_hh >= 8'h01) && (ld_hh <= 8'h12)));
        ld_ok    = ld_hh_ok &&
                   bcd_ok(ld_mm) && (ld_mm <= 8'h59) &&
                   bcd_ok(ld_ss) && (ld_ss <= 8'h59);
    end

    // Time one second after the current value, in the active hour format.
    always_comb begin
        ss_adv = bcd_inc(ss_q);
        mm_adv = mm_q;
        hh_adv = hh_q;
        pm_adv = pm_q;
        if (ss_q == 8'h59) begin
            ss_adv = 8'h00;
            mm_adv = bcd_inc(mm_q);
            if (mm_q == 8'h59) begin
                mm_adv = 8'h00;
                if (mode_q) begin
                    hh_adv = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
                    pm_adv = (hh_adv >= 8'h12);
                end else if (hh_q == 8'h12) begin
                    hh_adv = 8'h01;
                end else if (hh_q == 8'h11) begin
                    hh_adv = 8'h12;
                    pm_adv = ~pm_q;
                end else begin
                    hh_adv = bcd_inc(hh_q);
                end
            end
        end
    end

    always_comb begin
        mode_d     = mode_q;
        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        pm_d       = pm_q;
        pcnt_d     = pcnt_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (ld_ok) begin
                hh_d   = ld_hh;
                mm_d   = ld_mm;
                ss_d   = ld_ss;
                mode_d = mode24;
                pm_d   = mode24 ? (ld_hh >= 8'h12) : ld_pm;
                pcnt_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (ena) begin
            if (adv) begin
                hh_d       = hh_adv;
                mm_d       = mm_adv;
                ss_d       = ss_adv;
                pm_d       = pm_adv;
                pcnt_d     = '0;
                sec_tick_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= mode24;
            hh_q       <= mode24 ? 8'h00 : 8'h12;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            pm_q       <= 1'b0;
            pcnt_q     <= '0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            pm_q       <= pm_d;
            pcnt_q     <= pcnt_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign hh       = hh_q;
    assign mm       = mm_q;
    assign ss       = ss_q;
    assign pm       = pm_q;
    assign sec_tick = sec_tick_q;
    assign load_err = load_err_q;

    generate
        if (ALARM_EN) begin : g_alarm
            logic [7:0] alm_hh_q;
            logic [7:0] alm_mm_q;
            logic       alm_pm_q;
            logic       alarm_q, alarm_d;
            logic       hit;

            // Alarm registers hold raw values; an illegal setting simply never matches.
            always_comb begin
                hit = adv && alarm_on &&
                      (hh_adv == alm_hh_q) && (mm_adv == alm_mm_q) && (ss_adv == 8'h00) &&
                      (mode_q || (pm_adv == alm_pm_q));
                if (hit) begin
                    alarm_d = 1'b1;
                end else if (alarm_ack || !alarm_on) begin
                    alarm_d = 1'b0;
                end else begin
                    alarm_d = alarm_q;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    alm_hh_q <= mode24 ? 8'h00 : 8'h12;
                    alm_mm_q <= 8'h00;
                    alm_pm_q <= 1'b0;
                    alarm_q  <= 1'b0;
                end else begin
                    alarm_q <= alarm_d;
                    if (alm_wr) begin
                        alm_hh_q <= alm_hh;
                        alm_mm_q <= alm_mm;
                        alm_pm_q <= alm_pm;
                    end
                end
            end

            assign alarm = alarm_q;
        end else begin : g_no_alarm
            assign alarm = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_clock_alarm.sv
// Bench for bcd_clock_alarm: directed vector table plus random traffic against a seconds-of-day model.
module tb_bcd_clock_alarm;

    logic       clk;
    logic       reset, ena, mode24, load, ld_pm, alm_wr, alm_pm, alarm_on, alarm_ack;
    logic [7:0] ld_hh, ld_mm, ld_ss, alm_hh, alm_mm;

    logic [7:0] hh1, mm1, ss1, hh4, mm4, ss4;
    logic       pm1, tk1, er1, al1, pm4, tk4, er4, al4;
    logic [27:0] out1, out4;

    int n_chk;
    int n_pass;

    // Model state, index 0 = TICK_DIV 1 instance, index 1 = TICK_DIV 4 instance.
    int         m_tod[2];
    int         m_pcnt[2];
    bit         m_mode[2];
    bit         m_tick[2];
    bit         m_err[2];
    bit         m_alarm[2];
    logic [7:0] m_ahh[2];
    logic [7:0] m_amm[2];
    bit         m_apm[2];

    bcd_clock_alarm #(.TICK_DIV(1), .ALARM_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .alm_wr(alm_wr), .alm_hh(alm_hh), .alm_mm(alm_mm), .alm_pm(alm_pm),
        .alarm_on(alarm_on), .alarm_ack(alarm_ack),
        .hh(hh1), .mm(mm1), .ss(ss1), .pm(pm1), .sec_tick(tk1), .load_err(er1), .alarm(al1)
    );

    bcd_clock_alarm #(.TICK_DIV(4), .ALARM_EN(1'b1)) u4 (
        .clk(clk), .reset(reset), .ena(ena), .mode24(mode24), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .alm_wr(alm_wr), .alm_hh(alm_hh), .alm_mm(alm_mm), .alm_pm(alm_pm),
        .alarm_on(alarm_on), .alarm_ack(alarm_ack),
        .hh(hh4), .mm(mm4), .ss(ss4), .pm(pm4), .sec_tick(tk4), .load_err(er4), .alarm(al4)
    );

    assign out1 = {hh1, mm1, ss1, pm1, tk1, er1, al1};
    assign out4 = {hh4, mm4, ss4, pm4, tk4, er4, al4};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] int2bcd(int v);
        logic [3:0] a, b;
        a = 4'(v / 10);
        b = 4'(v % 10);
        return {a, b};
    endfunction

    function automatic bit digits_ok(logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic int bcd2int(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit ld_legal(bit m24, logic [7:0] h, logic [7:0] mi, logic [7:0] s);
        int hv;
        if (!digits_ok(h) || !digits_ok(mi) || !digits_ok(s)) return 1'b0;
        if (bcd2int(mi) > 59 || bcd2int(s) > 59) return 1'b0;
        hv = bcd2int(h);
        if (m24) return hv <= 23;
        return (hv >= 1) && (hv <= 12);
    endfunction

    // 12h hour h with pm flag maps to 24h hour (h mod 12) + 12*pm.
    function automatic int ld_tod(bit m24, logic [7:0] h, logic [7:0] mi, logic [7:0] s, bit p);
        int hv;
        hv = bcd2int(h);
        if (!m24) hv = (hv % 12) + (p ? 12 : 0);
        return hv * 3600 + bcd2int(mi) * 60 + bcd2int(s);
    endfunction

    function automatic bit alm_match(bit m24, logic [7:0] ah, logic [7:0] am, bit ap, int tod);
        int hv, mv;
        if (!digits_ok(ah) || !digits_ok(am)) return 1'b0;
        hv = bcd2int(ah);
        mv = bcd2int(am);
        if (mv > 59) return 1'b0;
        if (m24) begin
            if (hv > 23) return 1'b0;
        end else begin
            if (hv < 1 || hv > 12) return 1'b0;
            hv = (hv % 12) + (ap ? 12 : 0);
        end
        return tod == hv * 3600 + mv * 60;
    endfunction

    function automatic logic [27:0] mk(logic [7:0] h, logic [7:0] mi, logic [7:0] s,
                                       bit p, bit t, bit e, bit a);
        return {h, mi, s, p, t, e, a};
    endfunction

    function automatic logic [27:0] exp_vec(int d);
        int h, dh;
        h  = m_tod[d] / 3600;
        dh = m_mode[d] ? h : ((h % 12 == 0) ? 12 : h % 12);
        return mk(int2bcd(dh), int2bcd((m_tod[d] / 60) % 60), int2bcd(m_tod[d] % 60),
                  h >= 12, m_tick[d], m_err[d], m_alarm[d]);
    endfunction

    task automatic check(string nm, logic [27:0] got, logic [27:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit hit;
            hit = 1'b0;
            if (reset) begin
                m_mode[d]  = mode24;
                m_tod[d]   = 0;
                m_pcnt[d]  = 0;
                m_tick[d]  = 1'b0;
                m_err[d]   = 1'b0;
                m_alarm[d] = 1'b0;
                m_ahh[d]   = mode24 ? 8'h00 : 8'h12;
                m_amm[d]   = 8'h00;
                m_apm[d]   = 1'b0;
            end else begin
                m_tick[d] = 1'b0;
                m_err[d]  = 1'b0;
                if (load) begin
                    if (ld_legal(mode24, ld_hh, ld_mm, ld_ss)) begin
                        m_tod[d]  = ld_tod(mode24, ld_hh, ld_mm, ld_ss, ld_pm);
                        m_mode[d] = mode24;
                        m_pcnt[d] = 0;
                    end else begin
                        m_err[d] = 1'b1;
                    end
                end else if (ena) begin
                    if (m_pcnt[d] == ((d == 0) ? 0 : 3)) begin
                        m_pcnt[d] = 0;
                        m_tod[d]  = (m_tod[d] + 1) % 86400;
                        m_tick[d] = 1'b1;
                        hit = alarm_on && alm_match(m_mode[d], m_ahh[d], m_amm[d], m_apm[d], m_tod[d]);
                    end else begin
                        m_pcnt[d]++;
                    end
                end
                if (hit) m_alarm[d] = 1'b1;
                else if (alarm_ack || !alarm_on) m_alarm[d] = 1'b0;
                if (alm_wr) begin
                    m_ahh[d] = alm_hh;
                    m_amm[d] = alm_mm;
                    m_apm[d] = alm_pm;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("u1_model", out1, exp_vec(0));
        check("u4_model", out4, exp_vec(1));
    endtask

    task automatic do_load(bit m24, logic [7:0] h, logic [7:0] mi, logic [7:0] s, bit p);
        mode24 = m24;
        ld_hh  = h;
        ld_mm  = mi;
        ld_ss  = s;
        ld_pm  = p;
        load   = 1'b1;
        ena    = 1'b0;
        cyc();
        load   = 1'b0;
        alm_wr = 1'b0;
    endtask

    typedef struct {
        bit         m24;
        logic [7:0] h, mi, s;
        bit         p;
        int         nadv;
        bit         err;
        logic [7:0] eh, em, es;
        bit         ep;
    } vec_t;

    vec_t tbl[14];
    int   tick_cnt;

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b1; ena = 1'b0; mode24 = 1'b0; load = 1'b0;
        ld_hh = 8'h00; ld_mm = 8'h00; ld_ss = 8'h00; ld_pm = 1'b0;
        alm_wr = 1'b0; alm_hh = 8'h00; alm_mm = 8'h00; alm_pm = 1'b0;
        alarm_on = 1'b0; alarm_ack = 1'b0;

        tbl[0]  = '{1'b0, 8'h11, 8'h59, 8'h59, 1'b0, 1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1};
        tbl[1]  = '{1'b0, 8'h12, 8'h59, 8'h59, 1'b1, 1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1};
        tbl[2]  = '{1'b0, 8'h11, 8'h59, 8'h59, 1'b1, 1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 8'h23, 8'h59, 8'h59, 1'b0, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 8'h11, 8'h59, 8'h59, 1'b0, 1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1};
        tbl[5]  = '{1'b1, 8'h09, 8'h59, 8'h59, 1'b0, 1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{1'b1, 8'h19, 8'h45, 8'h30, 1'b0, 0, 1'b0, 8'h19, 8'h45, 8'h30, 1'b1};
        tbl[7]  = '{1'b0, 8'h01, 8'h02, 8'h03, 1'b1, 0, 1'b0, 8'h01, 8'h02, 8'h03, 1'b1};
        tbl[8]  = '{1'b0, 8'h13, 8'h00, 8'h00, 1'b0, 0, 1'b1, 8'h01, 8'h02, 8'h03, 1'b1};
        tbl[9]  = '{1'b0, 8'h05, 8'h5A, 8'h00, 1'b0, 0, 1'b1, 8'h01, 8'h02, 8'h03, 1'b1};
        tbl[10] = '{1'b1, 8'h24, 8'h00, 8'h00, 1'b0, 0, 1'b1, 8'h01, 8'h02, 8'h03, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 8'h10, 8'h10, 1'b0, 0, 1'b1, 8'h01, 8'h02, 8'h03, 1'b1};
        tbl[12] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 2, 1'b0, 8'h00, 8'h00, 8'h02, 1'b0};
        tbl[13] = '{1'b0, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b0};

        // Reset into 12h mode.
        cyc();
        cyc();
        reset = 1'b0;
        check("reset_u1", out1, mk(8'h12, 8'h00, 8'h00, 0, 0, 0, 0));
        check("reset_u4", out4, mk(8'h12, 8'h00, 8'h00, 0, 0, 0, 0));

        // One hour of seconds.
        ena = 1'b1;
        for (int i = 0; i < 3600; i++) cyc();
        ena = 1'b0;
        check("hour_u1", out1, mk(8'h01, 8'h00, 8'h00, 0, 1, 0, 0));
        check("hour_u4", out4, mk(8'h12, 8'h15, 8'h00, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            do_load(tbl[i].m24, tbl[i].h, tbl[i].mi, tbl[i].s, tbl[i].p);
            check("tbl_err", {27'd0, er1}, {27'd0, tbl[i].err});
            ena = 1'b1;
            for (int k = 0; k < tbl[i].nadv; k++) cyc();
            ena = 1'b0;
            check("tbl_time", {out1[27:3], 3'b000},
                  {tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].ep, 3'b000});
        end

        // Prescaler by 4: two advances in eight ena pulses.
        do_load(1'b1, 8'h10, 8'h00, 8'h00, 1'b0);
        tick_cnt = 0;
        ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            tick_cnt += int'(tk4);
        end
        check("div4_time", out4, mk(8'h10, 8'h00, 8'h02, 0, 1, 0, 0));
        check("div4_ticks", 28'(tick_cnt), 28'd2);
        for (int i = 0; i < 3; i++) cyc();
        ld_hh = 8'h10; ld_mm = 8'h20; ld_ss = 8'h30; load = 1'b1;
        cyc();
        load = 1'b0;
        check("div4_load_wins", out4, mk(8'h10, 8'h20, 8'h30, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) cyc();
        check("div4_restart", out4, mk(8'h10, 8'h20, 8'h30, 0, 0, 0, 0));
        cyc();
        check("div4_next", out4, mk(8'h10, 8'h20, 8'h31, 0, 1, 0, 0));
        ena = 1'b0;

        // Alarm at 07:30 am, written together with the load.
        alarm_on = 1'b1;
        alm_hh = 8'h07; alm_mm = 8'h30; alm_pm = 1'b0; alm_wr = 1'b1;
        do_load(1'b0, 8'h07, 8'h29, 8'h59, 1'b0);
        check("alm_load", out1, mk(8'h07, 8'h29, 8'h59, 0, 0, 0, 0));
        ena = 1'b1;
        cyc();
        ena = 1'b0;
        check("alm_set", out1, mk(8'h07, 8'h30, 8'h00, 0, 1, 0, 1));
        alarm_ack = 1'b1;
        cyc();
        alarm_ack = 1'b0;
        check("alm_ack", out1, mk(8'h07, 8'h30, 8'h00, 0, 0, 0, 0));
        do_load(1'b0, 8'h07, 8'h29, 8'h59, 1'b0);
        ena = 1'b1; alarm_ack = 1'b1;
        cyc();
        ena = 1'b0; alarm_ack = 1'b0;
        check("alm_set_beats_ack", out1, mk(8'h07, 8'h30, 8'h00, 0, 1, 0, 1));
        alarm_on = 1'b0;
        cyc();
        check("alm_off_clears", out1, mk(8'h07, 8'h30, 8'h00, 0, 0, 0, 0));
        do_load(1'b0, 8'h07, 8'h29, 8'h59, 1'b0);
        ena = 1'b1;
        cyc();
        ena = 1'b0;
        check("alm_off_blocks", out1, mk(8'h07, 8'h30, 8'h00, 0, 1, 0, 0));
        alarm_on = 1'b1;
        do_load(1'b0, 8'h07, 8'h30, 8'h00, 1'b0);
        check("alm_load_no_set", out1, mk(8'h07, 8'h30, 8'h00, 0, 0, 0, 0));
        do_load(1'b0, 8'h07, 8'h29, 8'h59, 1'b1);
        ena = 1'b1;
        cyc();
        ena = 1'b0;
        check("alm_pm_differs", out1, mk(8'h07, 8'h30, 8'h00, 1, 1, 0, 0));

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int t, h;
            reset     = ($urandom_range(0, 999) < 3);
            ena       = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 31) == 0);
            mode24    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) ld_hh = 8'($urandom);
            else ld_hh = mode24 ? int2bcd($urandom_range(0, 23)) : int2bcd($urandom_range(1, 12));
            if ($urandom_range(0, 7) == 0) ld_mm = 8'($urandom);
            else ld_mm = int2bcd($urandom_range(0, 59));
            ld_ss     = int2bcd($urandom_range(50, 59));
            ld_pm     = ($urandom_range(0, 1) == 1);
            alm_wr    = ($urandom_range(0, 39) == 0);
            t = (((m_tod[0] / 60) + 1) * 60) % 86400;
            h = t / 3600;
            if ($urandom_range(0, 1) == 0) begin
                alm_hh = m_mode[0] ? int2bcd(h) : int2bcd((h % 12 == 0) ? 12 : h % 12);
                alm_mm = int2bcd((t / 60) % 60);
                alm_pm = (h >= 12);
            end else begin
                alm_hh = 8'($urandom);
                alm_mm = int2bcd($urandom_range(0, 59));
                alm_pm = ($urandom_range(0, 1) == 1);
            end
            alarm_on  = ($urandom_range(0, 15) != 0);
            alarm_ack = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
